// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between the fetch port and the data port.
// Data has priority, a streak limiter guarantees fetch progress, and a timeout aborts dead transactions.
module mem_port_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_data,
  output logic                 i_ready,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic                 bus_err
);

  localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [7:0]    TMO_LIMIT  = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  state_t               state_reg, state_next;
  logic [SW-1:0]        streak_reg, streak_next;
  logic [7:0]           tmo_reg, tmo_next;
  logic                 mem_req_reg, mem_req_next;
  logic                 mem_we_reg, mem_we_next;
  logic [WORD_SIZE-1:0] mem_addr_reg, mem_addr_next;
  logic [WORD_SIZE-1:0] mem_wdata_reg, mem_wdata_next;
  logic [WORD_SIZE-1:0] i_data_reg, i_data_next;
  logic [WORD_SIZE-1:0] d_rdata_reg, d_rdata_next;
  logic                 i_ready_reg, i_ready_next;
  logic                 d_ready_reg, d_ready_next;
  logic                 bus_err_reg, bus_err_next;

  logic                 d_elig, i_elig, fetch_turn;
  logic [7:0]           tmo_inc;
  logic [WORD_SIZE-1:0] rd_word;

  // A requester whose ready pulse is showing this cycle is still holding its level request; mask it.
  assign d_elig     = (d_read | d_write) & ~d_ready_reg;
  assign i_elig     = i_req & ~i_ready_reg;
  assign fetch_turn = i_elig && (streak_reg == STREAK_MAX);
  assign tmo_inc    = tmo_reg + 8'd1;

  always_comb begin
    state_next     = state_reg;
    streak_next    = streak_reg;
    tmo_next       = tmo_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    i_data_next    = i_data_reg;
    d_rdata_next   = d_rdata_reg;
    i_ready_next   = 1'b0;
    d_ready_next   = 1'b0;
    bus_err_next   = bus_err_reg;
    rd_word        = '0;

    case (state_reg)
      IDLE: begin
        if (d_elig && !fetch_turn) begin
          state_next     = D_BUSY;
          mem_req_next   = 1'b1;
          mem_we_next    = d_write;
          mem_addr_next  = d_addr;
          mem_wdata_next = d_write ? d_wdata : '0;
          tmo_next       = '0;
          if (!i_elig)
            streak_next = '0;
          else if (streak_reg != STREAK_MAX)
            streak_next = streak_reg + SW'(1);
        end else if (i_elig) begin
          state_next     = I_BUSY;
          mem_req_next   = 1'b1;
          mem_we_next    = 1'b0;
          mem_addr_next  = i_addr;
          mem_wdata_next = '0;
          tmo_next       = '0;
          streak_next    = '0;
        end
      end

      I_BUSY, D_BUSY: begin
        if (mem_ack || (tmo_inc == TMO_LIMIT)) begin
          // An aborted transaction still releases its requester, with zero data.
          rd_word      = mem_ack ? mem_rdata : '0;
          bus_err_next = bus_err_reg | ~mem_ack;
          mem_req_next = 1'b0;
          state_next   = IDLE;
          if (state_reg == I_BUSY) begin
            i_data_next  = rd_word;
            i_ready_next = 1'b1;
          end else begin
            d_rdata_next = mem_we_reg ? '0 : rd_word;
            d_ready_next = 1'b1;
          end
        end else begin
          tmo_next = tmo_inc;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_reg     <= IDLE;
      streak_reg    <= '0;
      tmo_reg       <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      i_data_reg    <= '0;
      d_rdata_reg   <= '0;
      i_ready_reg   <= 1'b0;
      d_ready_reg   <= 1'b0;
      bus_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      streak_reg    <= streak_next;
      tmo_reg       <= tmo_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      i_data_reg    <= i_data_next;
      d_rdata_reg   <= d_rdata_next;
      i_ready_reg   <= i_ready_next;
      d_ready_reg   <= d_ready_next;
      bus_err_reg   <= bus_err_next;
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign i_data    = i_data_reg;
  assign d_rdata   = d_rdata_reg;
  assign i_ready   = i_ready_reg;
  assign d_ready   = d_ready_reg;
  assign bus_err   = bus_err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic, every cycle compared
// against a transaction-level reference model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int TB_TIMEOUT = 8;
  localparam int TB_MAXS    = 4;

  logic        Clk = 1'b0;
  logic        Reset_N = 1'b0;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic [15:0] i_data;
  logic        i_ready;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic [15:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        bus_err;

  mem_port_arbiter #(.WORD_SIZE(16), .MAX_D_STREAK(TB_MAXS), .TIMEOUT(TB_TIMEOUT)) dut (
    .Clk(Clk), .Reset_N(Reset_N),
    .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  // Reference model: the transaction in flight plus the visible result registers.
  bit          m_busy, m_own_d, m_we, m_i_ready, m_d_ready, m_err;
  int          m_age, m_streak;
  logic [15:0] m_addr, m_wdata, m_i_data, m_d_rdata;

  // Memory responder control.
  bit          ack_rand = 0;
  int          ack_lat = 0;
  logic [15:0] rd_val = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_own_d = 0; m_we = 0; m_i_ready = 0; m_d_ready = 0; m_err = 0;
    m_age = 0; m_streak = 0;
    m_addr = '0; m_wdata = '0; m_i_data = '0; m_d_rdata = '0;
  endtask

  task automatic model_step();
    bit d_el, f_el, nir, ndr, fin, ok;
    logic [15:0] rd;
    nir = 0; ndr = 0; fin = 0; ok = 0;
    d_el = (d_read || d_write) && !m_d_ready;
    f_el = i_req && !m_i_ready;
    if (!m_busy) begin
      if (d_el && !(f_el && m_streak == TB_MAXS)) begin
        m_busy = 1; m_own_d = 1; m_age = 0;
        m_addr = d_addr; m_we = d_write; m_wdata = d_write ? d_wdata : 16'h0;
        m_streak = f_el ? ((m_streak < TB_MAXS) ? m_streak + 1 : m_streak) : 0;
      end else if (f_el) begin
        m_busy = 1; m_own_d = 0; m_age = 0;
        m_addr = i_addr; m_we = 0; m_wdata = 16'h0;
        m_streak = 0;
      end
    end else begin
      if (mem_ack) begin
        fin = 1; ok = 1;
      end else begin
        m_age++;
        if (m_age == TB_TIMEOUT) begin fin = 1; m_err = 1; end
      end
      if (fin) begin
        rd = ok ? mem_rdata : 16'h0;
        m_busy = 0;
        if (m_own_d) begin m_d_rdata = m_we ? 16'h0 : rd; ndr = 1; end
        else begin m_i_data = rd; nir = 1; end
      end
    end
    m_i_ready = nir;
    m_d_ready = ndr;
  endtask

  task automatic check_all();
    chk("mem_req", mem_req, m_busy);
    chk("mem_we", mem_we, m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("i_ready", i_ready, m_i_ready);
    chk("d_ready", d_ready, m_d_ready);
    chk("i_data", i_data, m_i_data);
    chk("d_rdata", d_rdata, m_d_rdata);
    chk("bus_err", bus_err, m_err);
  endtask

  task automatic tick();
    if (ack_rand) mem_ack = ($urandom_range(0, 2) == 0);
    else          mem_ack = m_busy && (ack_lat >= 0) && (m_age == ack_lat);
    mem_rdata = ack_rand ? 16'($urandom) : rd_val;
    model_step();
    @(posedge Clk);
    #1;
    check_all();
  endtask

  task automatic wait_ready(input bit want_d, input string tag);
    bit seen;
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      tick();
      if (want_d ? d_ready : i_ready) seen = 1;
    end
    chk(tag, seen, 1);
  endtask

  initial begin
    int cnt;
    int grants;
    int d_before;
    bit seen_fetch;
    bit prev_req;
    logic [15:0] g_addr [0:5];

    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check_all();
    @(negedge Clk);
    Reset_N = 1'b1;

    // Single fetch, memory acks in the third busy cycle.
    i_req = 1; i_addr = 16'h0010; ack_lat = 2; rd_val = 16'h6A01;
    tick();
    chk("fetch_addr", mem_addr, 16'h0010);
    chk("fetch_we", mem_we, 0);
    wait_ready(0, "fetch_ready");
    chk("fetch_data", i_data, 16'h6A01);
    chk("fetch_no_dready", d_ready, 0);
    i_req = 0;

    // Collision: data first, fetch taken in the data ready cycle.
    i_req = 1; i_addr = 16'h0010; d_read = 1; d_addr = 16'h0100; ack_lat = 1; rd_val = 16'h1111;
    tick();
    chk("coll_data_addr", mem_addr, 16'h0100);
    wait_ready(1, "coll_dready");
    chk("coll_no_iready", i_ready, 0);
    d_read = 0; rd_val = 16'h2222;
    tick();
    chk("coll_fetch_req", mem_req, 1);
    chk("coll_fetch_addr", mem_addr, 16'h0010);
    wait_ready(0, "coll_iready");
    chk("coll_fetch_data", i_data, 16'h2222);
    i_req = 0;

    // Store; requester changes address and data while busy.
    d_write = 1; d_addr = 16'h0020; d_wdata = 16'hBEEF; ack_lat = 3; rd_val = 16'h5555;
    tick();
    chk("store_we", mem_we, 1);
    chk("store_wdata", mem_wdata, 16'hBEEF);
    d_wdata = 16'h1234; d_addr = 16'h9999;
    wait_ready(1, "store_dready");
    chk("store_rdata", d_rdata, 16'h0000);
    d_write = 0;

    // Streak limiter: fetch pending at every data grant but idle in the data ready cycles.
    d_read = 1; d_addr = 16'h0200; i_addr = 16'h0300; ack_lat = 0; rd_val = 16'h7777;
    grants = 0; prev_req = mem_req;
    for (int k = 0; k < 80 && grants < 6; k++) begin
      i_req = !m_d_ready;
      tick();
      if (!prev_req && mem_req === 1'b1) begin
        g_addr[grants] = mem_addr;
        grants++;
      end
      prev_req = mem_req;
    end
    chk("streak_grants", grants, 6);
    d_before = 0; seen_fetch = 0;
    for (int k = 0; k < grants; k++) begin
      if (g_addr[k] == 16'h0300) seen_fetch = 1;
      else if (!seen_fetch) d_before++;
    end
    chk("streak_data_run", d_before, TB_MAXS);
    chk("streak_fetch_grant", g_addr[4], 16'h0300);
    chk("streak_data_resume", g_addr[5], 16'h0200);
    d_read = 0; i_req = 0;
    repeat (4) tick();

    // Timeout on a fetch, then a successful data read keeps bus_err set.
    i_req = 1; i_addr = 16'h0040; ack_lat = -1;
    tick();
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (mem_req !== 1'b1) break;
      cnt++;
      tick();
    end
    chk("timeout_busy_cycles", cnt, TB_TIMEOUT);
    chk("timeout_iready", i_ready, 1);
    chk("timeout_data", i_data, 16'h0000);
    chk("timeout_err", bus_err, 1);
    i_req = 0; d_read = 1; d_addr = 16'h0050; ack_lat = 1; rd_val = 16'h3C3C;
    tick();
    wait_ready(1, "post_err_dready");
    chk("post_err_data", d_rdata, 16'h3C3C);
    chk("err_sticky", bus_err, 1);

    // Asynchronous reset while a data read is in flight.
    d_addr = 16'h0077; ack_lat = -1;
    repeat (3) tick();
    chk("pre_reset_req", mem_req, 1);
    #3;
    Reset_N = 1'b0;
    #1;
    chk("async_mem_req", mem_req, 0);
    chk("async_mem_addr", mem_addr, 16'h0000);
    chk("async_bus_err", bus_err, 0);
    chk("async_d_ready", d_ready, 0);
    chk("async_i_data", i_data, 16'h0000);
    model_reset();
    d_read = 0; i_req = 1; i_addr = 16'h0088; ack_lat = 1; rd_val = 16'hABCD;
    @(negedge Clk);
    Reset_N = 1'b1;
    tick();
    chk("post_reset_addr", mem_addr, 16'h0088);
    wait_ready(0, "post_reset_iready");
    chk("post_reset_data", i_data, 16'hABCD);
    i_req = 0;

    // Random traffic with random acknowledge timing.
    ack_rand = 1;
    for (int k = 0; k < 600; k++) begin
      i_req   = ($urandom_range(0, 2) != 0);
      d_read  = ($urandom_range(0, 2) == 0);
      d_write = ($urandom_range(0, 3) == 0);
      i_addr  = 16'($urandom);
      d_addr  = 16'($urandom);
      d_wdata = 16'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch port (port 1) and its data port (port 2).
- Converts the datapath's two level-held requests into one memory transaction at a time, with a request/acknowledge handshake on the memory side.
- Returns one-cycle ready pulses that the pipeline uses as stall-release for IF or MEM.
- Data port has priority; a streak limiter prevents fetch starvation; a timeout guards against a dead memory.

Parameters:
WORD_SIZE, 16, width of addresses and data
MAX_D_STREAK, 4, consecutive data grants allowed while a fetch is pending
TIMEOUT, 255, cycles to wait for mem_ack before aborting (≤ 255; counter is 8 bits)

Ports:
Clk  in  1  clock, rising edge
Reset_N  in  1  asynchronous active-low reset
i_req  in  1  fetch request (readM1), level, held until i_ready
i_addr  in  WORD_SIZE  fetch address (address1)
i_data  out  WORD_SIZE  fetched word, valid while i_ready=1
i_ready  out  1  one-cycle fetch completion pulse
d_read  in  1  data read request (readM2), level
d_write  in  1  data write request (writeM2), level
d_addr  in  WORD_SIZE  data address (address2)
d_wdata  in  WORD_SIZE  store data
d_rdata  out  WORD_SIZE  load data, valid while d_ready=1
d_ready  out  1  one-cycle data completion pulse
mem_req  out  1  memory transaction request, registered
mem_we  out  1  1=write, registered
mem_addr  out  WORD_SIZE  registered address
mem_wdata  out  WORD_SIZE  registered store data
mem_rdata  in  WORD_SIZE  memory read data, valid with mem_ack
mem_ack  in  1  one-cycle completion from memory
bus_err  out  1  sticky timeout flag

Behaviour:
- Reset (async, Reset_N=0): state=IDLE; all outputs 0; streak and timeout counters 0. A transaction in flight is dropped and mem_req falls immediately. No ready pulse is issued for it.
- States: IDLE, I_BUSY, D_BUSY.
- IDLE grant rule, evaluated each rising edge:
  - Eligible data request: (d_read|d_write) & !d_ready.
  - Eligible fetch request: i_req & !i_ready. The ready term masks the requester that is releasing this cycle.
  - Data wins, unless a fetch is eligible and streak==MAX_D_STREAK; then the fetch wins.
  - Data grant: streak+=1 (saturating). Fetch grant: streak=0. No fetch pending at a data grant: streak stays 0.
- On grant: register mem_req=1, mem_addr, mem_we (1 only for data write), mem_wdata (d_wdata on write, else 0). Go to I_BUSY or D_BUSY. Clear the timeout counter.
- d_read & d_write both high: treated as a write.
- BUSY:
  - mem_req and all mem_* outputs are held stable until mem_ack.
  - The timeout counter increments each cycle without mem_ack.
  - Edge with mem_ack=1: mem_req←0; read data is captured into i_data or d_rdata; the matching ready ←1 for exactly one cycle; state←IDLE.
  - Write completion: d_rdata←0.
- Latency:
  - Grant is registered one edge after the request is seen.
  - With mem_ack in the first BUSY cycle, ready is high in the 3rd cycle after the request appears.
  - Back-to-back transactions are separated by at least one IDLE cycle (the ready cycle).
- Timeout: counter reaches TIMEOUT in BUSY with no mem_ack → abort. mem_req←0, ready pulse with data 0, bus_err←1 (sticky until reset), state←IDLE.
- mem_ack in IDLE is ignored.
- Requester address or data changes during BUSY are ignored; the registered values are used.
- A request dropped during BUSY still completes; the ready pulse is issued anyway.
- i_data and d_rdata hold their last value outside ready cycles.

Test Plan:
- Single fetch: i_req=1, i_addr=16'h0010, memory acks 2 cycles after mem_req with 16'h6A01 → mem_addr=16'h0010, mem_we=0; i_ready high one cycle with i_data=16'h6A01; no d_ready.
- Collision: i_req and d_read asserted the same cycle, d_addr=16'h0100 → data granted first (mem_addr=16'h0100); fetch granted in the IDLE cycle after d_ready; two separate ready pulses, in data-then-fetch order.
- Starvation: d_read held continuously with i_req=1 and MAX_D_STREAK=4 → exactly 4 data grants, then 1 fetch grant, then data resumes; streak resets to 0.
- Store: d_write=1, d_addr=16'h0020, d_wdata=16'hBEEF → mem_we=1, mem_wdata=16'hBEEF held until mem_ack; d_ready pulses; d_rdata=0.
- Timeout: TIMEOUT=8, mem_ack never asserted → mem_req drops after 8 BUSY cycles; ready pulse with data 0; bus_err=1 and stays 1 through later successful transactions.
- Async reset mid-transaction: Reset_N low in D_BUSY between edges → mem_req and all outputs go to 0 without waiting for a clock edge; after release, a held i_req is granted normally.
